pulso_a_impulso: RTL and testbench
==================================

# pulso_a_impulso

Converts a clean, debounced level or pulse on `botonLimpio` into a single fixed-width synchronous impulse on `impulso`, one per rising edge of the input. It sits between the button debouncer and the memory-controller command logic. Each button press must advance or trigger exactly one operation, however long the button is held.

## Interface
Parameters:
- `SYNC_STAGES`, default 0: extra flip-flop stages on `botonLimpio` before edge detection (0..4). Use 0 when the input is already synchronous to `clock`.
- `PULSE_CYCLES`, default 1: width of `impulso` in `clock` cycles (1..255).
- `HOLDOFF_CYCLES`, default 0: cycles after `impulso` deasserts during which new input edges are ignored (0..65535).

Ports:
- `clock`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Assertion clears all state immediately; release is sampled on `clock`.
- `botonLimpio`, input, 1: clean, debounced button level. Active high.
- `impulso`, output, 1: registered impulse. High for exactly `PULSE_CYCLES` cycles per accepted rising edge.
- `ocupado`, output, 1: registered. High while `impulso` is high or the holdoff is running; low otherwise.

## Operation
- Input path: `botonLimpio` passes through `SYNC_STAGES` flops to form `s`. A history flop `s_prev` holds `s` from the previous cycle.
  - With `SYNC_STAGES`=0, `s` is `botonLimpio` sampled at the current edge.
- Edge detect: `rise` = `s` & ~`s_prev`. Only rising edges matter; falling edges and held-high input are ignored.
- State machine (registered):
  - IDLE: `impulso`=0, `ocupado`=0. On `rise`, load the width counter with `PULSE_CYCLES`-1 and go to PULSE.
  - PULSE: `impulso`=1, `ocupado`=1. Count down. At 0, go to HOLD if `HOLDOFF_CYCLES`>0, else go to IDLE. Any `rise` in this state is discarded.
  - HOLD: `impulso`=0, `ocupado`=1. Count down `HOLDOFF_CYCLES`, then go to IDLE. Any `rise` in this state is discarded and not queued.
- A `rise` on the same cycle that HOLD or PULSE returns to IDLE is discarded. Only edges sampled while already in IDLE are accepted.
- Holding the input high indefinitely produces exactly one impulse.
- Counters are sized by `$clog2` of the parameter values. No wrap-around beyond the loaded value.

## Timing
- Reset value: `impulso`=0, `ocupado`=0, state=IDLE, `s_prev`=0, all sync flops 0.
- If `botonLimpio` is already high when reset releases, `s_prev`=0 means the first sampled 1 counts as a rise and one impulse is generated.
- Latency with `SYNC_STAGES`=0:
  - `botonLimpio` first sampled high at clock edge k.
  - `impulso` rises just after edge k and falls just after edge k+`PULSE_CYCLES`.
- Each sync stage adds one cycle of latency.
- Minimum accepted input high time: 1 clock period, sampled at one rising edge. Narrower pulses that miss an edge are not seen.
- Minimum spacing between accepted presses: `PULSE_CYCLES`+`HOLDOFF_CYCLES` cycles, plus one low sample of `s` so that `s_prev` can return to 0.
- Reset asserted mid-PULSE or mid-HOLD: outputs go to 0 immediately (asynchronous). After release, a still-high input produces a new impulse, per the rule above.

## Test plan
- Defaults, 10 ns clock with edges at 5, 15, ... ns; `botonLimpio` 0 until 100 ns, 1 for 100–110 ns, then 0 -> `impulso` high 105–115 ns only; `ocupado` matches it.
- Defaults, input held high from 200 ns to 1000 ns -> exactly one 1-cycle impulse at 205 ns; no further impulses.
- `PULSE_CYCLES`=4, `HOLDOFF_CYCLES`=3; two presses 2 cycles apart -> one 4-cycle impulse; second press ignored; `ocupado` high for 7 cycles.
- Same parameters; second press 9 cycles after the first -> two 4-cycle impulses.
- `SYNC_STAGES`=2, defaults otherwise -> impulse begins 2 cycles later than in scenario 1, still 1 cycle wide.
- `reset` pulled low mid-impulse with `PULSE_CYCLES`=4 and input still high -> `impulso` drops at once; after release, one new impulse is produced on the first edge.

Source files
------------

// File: rtl/pulso_a_impulso.sv
// Turns each accepted rising edge of a debounced button level into one
// fixed-width impulse, followed by an optional holdoff window that swallows new edges.
module pulso_a_impulso #(
  parameter int SYNC_STAGES    = 0,
  parameter int PULSE_CYCLES   = 1,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic botonLimpio,
  output logic impulso,
  output logic ocupado
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int CW = (PW > HW) ? PW : HW;

  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] H_LOAD = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

  logic          s;
  logic          rise;
  logic          s_prev_q, s_prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          impulso_q, impulso_d;
  logic          ocupado_q, ocupado_d;

  // With no sync stages the raw input is sampled directly by s_prev and the FSM.
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign s = botonLimpio;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d[0] = botonLimpio;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign rise = s & ~s_prev_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_prev_d = s;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PULSE;
          cnt_d   = P_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLD;
            cnt_d   = H_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        // Edges seen here are dropped, not queued.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they are registered alongside it.
    impulso_d = (state_d == PULSE);
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_prev_q  <= 1'b0;
      impulso_q <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_prev_q  <= s_prev_d;
      impulso_q <= impulso_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign impulso = impulso_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_pulso_a_impulso.sv
// Directed bench: default, long-pulse/holdoff and two-stage-sync instances share one clock and reset.
`timescale 1ns/1ps
module tb_pulso_a_impulso;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
  logic imp_a, ocp_a, imp_b, ocp_b, imp_c, ocp_c;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulso_a_impulso dut_a (
    .clock(clk), .reset(rst_n), .botonLimpio(btn_a), .impulso(imp_a), .ocupado(ocp_a)
  );

  pulso_a_impulso #(.SYNC_STAGES(0), .PULSE_CYCLES(4), .HOLDOFF_CYCLES(3)) dut_b (
    .clock(clk), .reset(rst_n), .botonLimpio(btn_b), .impulso(imp_b), .ocupado(ocp_b)
  );

  pulso_a_impulso #(.SYNC_STAGES(2)) dut_c (
    .clock(clk), .reset(rst_n), .botonLimpio(btn_c), .impulso(imp_c), .ocupado(ocp_c)
  );

  // Absolute-time stimulus for the default and synchronised instances.
  initial begin
    #100 btn_a = 1'b1; btn_c = 1'b1;
    #10  btn_a = 1'b0; btn_c = 1'b0;
    #90  btn_a = 1'b1;
    #800 btn_a = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({imp_a, ocp_a, imp_b, ocp_b, imp_c, ocp_c} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000",
               {imp_a, ocp_a, imp_b, ocp_b, imp_c, ocp_c});
    end
    #1 rst_n = 1'b1;
  endtask

  // One-cycle press at 100-110 ns: default impulse at 105-115, sync2 impulse at 125-135.
  task automatic test_single_press();
    logic exp_a, exp_c;
    do begin
      tick();
      exp_a = ($time == 106);
      exp_c = ($time == 126);
      n_cmp++;
      if (imp_a !== exp_a || ocp_a !== exp_a) begin
        n_err++;
        $display("FAIL single_press @%0t: impulso=%b ocupado=%b want %b", $time, imp_a, ocp_a, exp_a);
      end
      n_cmp++;
      if (imp_c !== exp_c || ocp_c !== exp_c) begin
        n_err++;
        $display("FAIL sync2_press @%0t: impulso=%b ocupado=%b want %b", $time, imp_c, ocp_c, exp_c);
      end
    end while ($time < 186);
  endtask

  // Input high 200-1000 ns: exactly one impulse just after 205 ns.
  task automatic test_held_high();
    logic exp_a;
    int n_imp = 0;
    do begin
      tick();
      exp_a = ($time == 206);
      if (imp_a) n_imp++;
      n_cmp++;
      if (imp_a !== exp_a || ocp_a !== exp_a) begin
        n_err++;
        $display("FAIL held_high @%0t: impulso=%b ocupado=%b want %b", $time, imp_a, ocp_a, exp_a);
      end
    end while ($time < 1026);
    n_cmp++;
    if (n_imp != 1) begin
      n_err++;
      $display("FAIL held_high_count: got %0d impulse cycles want 1", n_imp);
    end
  endtask

  // PULSE=4, HOLDOFF=3: one-cycle presses at relative edges 0 and 'second'.
  task automatic test_two_presses(input string name, input int second, input bit accepted);
    logic exp_i, exp_o;
    for (int c = 0; c < second + 10; c++) begin
      btn_b = (c == 0) || (c == second);
      tick();
      exp_i = (c < 4) || (accepted && c >= second && c < second + 4);
      exp_o = (c < 7) || (accepted && c >= second && c < second + 7);
      n_cmp++;
      if (imp_b !== exp_i || ocp_b !== exp_o) begin
        n_err++;
        $display("FAIL %s c=%0d: impulso=%b ocupado=%b want %b %b", name, c, imp_b, ocp_b, exp_i, exp_o);
      end
    end
    btn_b = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_i, exp_o;
    btn_b = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (imp_b !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pulse_pre: impulso=%b want 1", imp_b);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imp_b !== 1'b0 || ocp_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: impulso=%b ocupado=%b want 0 0", imp_b, ocp_b);
    end
    #2 rst_n = 1'b1;
    // Input still high: s_prev was cleared, so the first edge is a new rise.
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_i = (c < 4);
      exp_o = (c < 7);
      n_cmp++;
      if (imp_b !== exp_i || ocp_b !== exp_o) begin
        n_err++;
        $display("FAIL after_reset c=%0d: impulso=%b ocupado=%b want %b %b", c, imp_b, ocp_b, exp_i, exp_o);
      end
    end
    btn_b = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_held_high();
    test_two_presses("press_ignored", 2, 1'b0);
    test_two_presses("back_to_back", 9, 1'b1);
    test_two_presses("edge_at_return", 7, 1'b0);
    test_two_presses("first_idle_edge", 8, 1'b1);
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
